// File: rtl/writeback_stage.sv
// W pipeline register and commit logic: register-file write port, program status,
// sticky halt and retired/cycle counters for the five-stage Y86-64 pipeline.
module writeback_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       m_icode,
  input  logic [3:0]       M_dstE,
  input  logic [3:0]       M_dstM,
  input  logic [63:0]      M_valE,
  input  logic [63:0]      m_valM,
  input  logic             W_stall,
  input  logic             W_bubble,
  output logic [3:0]       W_stat,
  output logic [3:0]       W_icode,
  output logic [3:0]       W_dstE,
  output logic [3:0]       W_dstM,
  output logic [63:0]      W_valE,
  output logic [63:0]      W_valM,
  output logic [3:0]       Stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
);

  localparam int unsigned DW        = 64;
  localparam logic [3:0]  STAT_AOK  = 4'h1;
  localparam logic [3:0]  ICODE_NOP = 4'h1;
  localparam logic [3:0]  REG_NONE  = 4'hF;

  typedef struct packed {
    logic [3:0]    stat;
    logic [3:0]    icode;
    logic [3:0]    dst_e;
    logic [3:0]    dst_m;
    logic [DW-1:0] val_e;
    logic [DW-1:0] val_m;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{
    stat:  STAT_AOK,
    icode: ICODE_NOP,
    dst_e: REG_NONE,
    dst_m: REG_NONE,
    val_e: '0,
    val_m: '0
  };

  w_reg_t           w_d, w_q;
  logic             halted_d, halted_q;
  logic [CNT_W-1:0] retired_d, retired_q;
  logic [CNT_W-1:0] cycles_d, cycles_q;

  // Next-state: halt freezes everything; stall beats bubble beats normal load.
  always_comb begin
    w_d       = w_q;
    halted_d  = halted_q;
    retired_d = retired_q;
    cycles_d  = cycles_q;
    if (!halted_q) begin
      if (cycles_q != '1) cycles_d = cycles_q + CNT_W'(1);
      if (!W_stall) begin
        if (W_bubble) begin
          w_d = W_BUBBLE;
        end else begin
          w_d = '{stat: m_stat, icode: m_icode, dst_e: M_dstE, dst_m: M_dstM,
                  val_e: M_valE, val_m: m_valM};
          if (m_stat != STAT_AOK) begin
            halted_d = 1'b1;
          end else if (m_icode != ICODE_NOP && retired_q != '1) begin
            retired_d = retired_q + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q       <= W_BUBBLE;
      halted_q  <= 1'b0;
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      w_q       <= w_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
      cycles_q  <= cycles_d;
    end
  end

  // Excepting instructions must neither write the register file nor forward.
  assign W_dstE  = (w_q.stat == STAT_AOK) ? w_q.dst_e : REG_NONE;
  assign W_dstM  = (w_q.stat == STAT_AOK) ? w_q.dst_m : REG_NONE;
  assign W_stat  = w_q.stat;
  assign W_icode = w_q.icode;
  assign W_valE  = w_q.val_e;
  assign W_valM  = w_q.val_m;
  assign Stat    = w_q.stat;
  assign halted  = halted_q;
  assign retired = retired_q;
  assign cycles  = cycles_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

  localparam int unsigned CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic [3:0]       m_stat, m_icode, M_dstE, M_dstM;
  logic [63:0]      M_valE, m_valM;
  logic             W_stall, W_bubble;
  logic [3:0]       W_stat, W_icode, W_dstE, W_dstM, Stat;
  logic [63:0]      W_valE, W_valM;
  logic             halted;
  logic [CNT_W-1:0] retired, cycles;

  int errors = 0;
  int checks = 0;

  writeback_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_stat(m_stat), .m_icode(m_icode), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .M_valE(M_valE), .m_valM(m_valM), .W_stall(W_stall), .W_bubble(W_bubble),
    .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM), .Stat(Stat), .halted(halted),
    .retired(retired), .cycles(cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic [3:0] st, input logic [3:0] ic, input logic [3:0] de,
                       input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
    m_stat = st; m_icode = ic; M_dstE = de; M_dstM = dm; M_valE = ve; m_valM = vm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; W_stall = 1'b0; W_bubble = 1'b0;
    drive(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
          {$urandom, $urandom}, {$urandom, $urandom});
    #23;
    checks++; if (W_stat !== 4'd1) begin errors++; $display("FAIL reset_stat got=%0d exp=1", W_stat); end
    checks++; if (W_icode !== 4'd1) begin errors++; $display("FAIL reset_icode got=%0d exp=1", W_icode); end
    checks++; if (W_dstE !== 4'd15 || W_dstM !== 4'd15) begin errors++; $display("FAIL reset_dst got=%0d/%0d exp=15/15", W_dstE, W_dstM); end
    checks++; if (W_valE !== 64'd0 || W_valM !== 64'd0) begin errors++; $display("FAIL reset_vals got=%h/%h exp=0/0", W_valE, W_valM); end
    checks++; if (halted !== 1'b0 || retired !== 0 || cycles !== 0) begin errors++; $display("FAIL reset_ctrs got=%0d/%0d/%0d exp=0/0/0", halted, retired, cycles); end
    @(posedge clk); #2;
    drive(4'd1, 4'd1, 4'd15, 4'd15, 64'd0, 64'd0);
    rst_n = 1'b1;
    repeat (3) step();
    checks++; if (cycles !== 3 || retired !== 0) begin errors++; $display("FAIL idle_ctrs got cycles=%0d retired=%0d exp=3/0", cycles, retired); end
  endtask

  task automatic test_normal_load();
    drive(4'd1, 4'd6, 4'd3, 4'd15, 64'h1234, 64'd0);
    step();
    checks++; if (W_dstE !== 4'd3 || W_valE !== 64'h1234) begin errors++; $display("FAIL load_e got=%0d/%h exp=3/1234", W_dstE, W_valE); end
    checks++; if (W_dstM !== 4'd15 || W_icode !== 4'd6) begin errors++; $display("FAIL load_m got dstM=%0d icode=%0d exp=15/6", W_dstM, W_icode); end
    checks++; if (retired !== 1 || cycles !== 4) begin errors++; $display("FAIL load_ctrs got=%0d/%0d exp=1/4", retired, cycles); end
  endtask

  task automatic test_stall_bubble();
    drive(4'd1, 4'd5, 4'd15, 4'd2, 64'd0, 64'd7);
    step();
    checks++; if (W_dstM !== 4'd2 || W_valM !== 64'd7 || retired !== 2) begin errors++; $display("FAIL mrm_load got=%0d/%0d/%0d exp=2/7/2", W_dstM, W_valM, retired); end
    W_stall = 1'b1;
    drive(4'd1, 4'd6, 4'd9, 4'd9, 64'd55, 64'd99);
    step();
    drive(4'd1, 4'd2, 4'd8, 4'd8, 64'd66, 64'd88);
    step();
    checks++; if (W_dstM !== 4'd2 || W_valM !== 64'd7 || W_icode !== 4'd5) begin errors++; $display("FAIL stall_hold got=%0d/%0d/%0d exp=2/7/5", W_dstM, W_valM, W_icode); end
    checks++; if (retired !== 2 || cycles !== 7) begin errors++; $display("FAIL stall_ctrs got=%0d/%0d exp=2/7", retired, cycles); end
    W_bubble = 1'b1;
    step();
    checks++; if (W_dstM !== 4'd2 || W_valM !== 64'd7 || W_icode !== 4'd5) begin errors++; $display("FAIL stall_over_bubble got=%0d/%0d/%0d exp=2/7/5", W_dstM, W_valM, W_icode); end
    W_stall = 1'b0;
    step();
    W_bubble = 1'b0;
    checks++; if (W_icode !== 4'd1 || W_dstE !== 4'd15 || W_dstM !== 4'd15 || W_stat !== 4'd1) begin errors++; $display("FAIL bubble got icode=%0d dst=%0d/%0d stat=%0d exp=1 15/15 1", W_icode, W_dstE, W_dstM, W_stat); end
    checks++; if (W_valM !== 64'd0 || retired !== 2 || cycles !== 9) begin errors++; $display("FAIL bubble_misc got valM=%0d ret=%0d cyc=%0d exp=0/2/9", W_valM, retired, cycles); end
  endtask

  task automatic test_halt_freeze();
    drive(4'd2, 4'd0, 4'd7, 4'd8, 64'hAA, 64'hBB);
    step();
    checks++; if (halted !== 1'b1 || cycles !== 10 || retired !== 2) begin errors++; $display("FAIL halt_edge got=%0d/%0d/%0d exp=1/10/2", halted, cycles, retired); end
    checks++; if (W_stat !== 4'd2 || Stat !== 4'd2 || W_dstE !== 4'd15 || W_dstM !== 4'd15) begin errors++; $display("FAIL halt_stat got=%0d/%0d/%0d/%0d exp=2/2/15/15", W_stat, Stat, W_dstE, W_dstM); end
    for (int i = 0; i < 5; i++) begin
      drive(4'd1, 4'(i + 2), 4'(i), 4'(i + 1), 64'(i * 3 + 1), 64'(i * 5 + 2));
      W_bubble = (i == 2); W_stall = (i == 3);
      step();
    end
    W_bubble = 1'b0; W_stall = 1'b0;
    checks++; if (W_stat !== 4'd2 || W_icode !== 4'd0 || W_valE !== 64'hAA || W_valM !== 64'hBB) begin errors++; $display("FAIL freeze_w got=%0d/%0d/%h/%h exp=2/0/aa/bb", W_stat, W_icode, W_valE, W_valM); end
    checks++; if (halted !== 1'b1 || cycles !== 10 || retired !== 2) begin errors++; $display("FAIL freeze_ctrs got=%0d/%0d/%0d exp=1/10/2", halted, cycles, retired); end
  endtask

  task automatic test_reset_while_halted();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (W_stat !== 4'd1 || W_icode !== 4'd1 || W_valE !== 64'd0 || W_valM !== 64'd0) begin errors++; $display("FAIL async_rst_w got=%0d/%0d/%h/%h exp=1/1/0/0", W_stat, W_icode, W_valE, W_valM); end
    checks++; if (halted !== 1'b0 || cycles !== 0 || retired !== 0) begin errors++; $display("FAIL async_rst_ctrs got=%0d/%0d/%0d exp=0/0/0", halted, cycles, retired); end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    drive(4'd1, 4'd2, 4'd1, 4'd15, 64'hA, 64'd0);
    step();
    checks++; if (W_icode !== 4'd2 || W_dstE !== 4'd1 || W_valE !== 64'hA || retired !== 1 || cycles !== 1) begin errors++; $display("FAIL b2b_rrm got=%0d/%0d/%h/%0d/%0d exp=2/1/a/1/1", W_icode, W_dstE, W_valE, retired, cycles); end
    drive(4'd1, 4'd1, 4'd15, 4'd15, 64'd0, 64'd0);
    step();
    checks++; if (W_icode !== 4'd1 || retired !== 1) begin errors++; $display("FAIL b2b_nop got=%0d/%0d exp=1/1", W_icode, retired); end
    drive(4'd1, 4'd5, 4'd15, 4'd4, 64'd0, 64'hC);
    step();
    checks++; if (W_dstM !== 4'd4 || W_valM !== 64'hC || retired !== 2) begin errors++; $display("FAIL b2b_mrm got=%0d/%h/%0d exp=4/c/2", W_dstM, W_valM, retired); end
    drive(4'd1, 4'd11, 4'd4, 4'd3, 64'hE, 64'hF0);
    step();
    checks++; if (W_dstE !== 4'd4 || W_dstM !== 4'd3 || W_valE !== 64'hE || W_valM !== 64'hF0) begin errors++; $display("FAIL b2b_pop got=%0d/%0d/%h/%h exp=4/3/e/f0", W_dstE, W_dstM, W_valE, W_valM); end
    checks++; if (retired !== 3 || cycles !== 4) begin errors++; $display("FAIL b2b_ctrs got=%0d/%0d exp=3/4", retired, cycles); end
  endtask

  task automatic test_exception_gating();
    drive(4'd3, 4'd5, 4'd15, 4'd4, 64'd0, 64'd5);
    step();
    checks++; if (W_stat !== 4'd3 || Stat !== 4'd3 || W_icode !== 4'd5) begin errors++; $display("FAIL exc_stat got=%0d/%0d/%0d exp=3/3/5", W_stat, Stat, W_icode); end
    checks++; if (W_dstM !== 4'd15 || W_dstE !== 4'd15 || W_valM !== 64'd5) begin errors++; $display("FAIL exc_gate got=%0d/%0d/%h exp=15/15/5", W_dstM, W_dstE, W_valM); end
    checks++; if (halted !== 1'b1 || retired !== 3 || cycles !== 5) begin errors++; $display("FAIL exc_ctrs got=%0d/%0d/%0d exp=1/3/5", halted, retired, cycles); end
  endtask

  initial begin
    test_reset();
    test_normal_load();
    test_stall_bubble();
    test_halt_freeze();
    test_reset_while_halted();
    test_back_to_back();
    test_exception_gating();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
